dram_arbiter: RTL

- Shares the single DRAM controller port between two requesters.
- Port 0 is the CPU memory-map path; port 1 is a secondary master (display/DMA reader).
- Round-robin arbitration, one outstanding DRAM transaction at a time.
- Registered request latching; drives the controller's start strobe, address, write enable and write data; returns read data with a one-cycle ack per port.

---
 rtl/dram_arbiter_if.sv | 38 +++
 rtl/dram_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dram_arbiter_if.sv
// rtl/dram_arbiter_if.sv - requester and DRAM controller signal bundle for dram_arbiter
interface dram_arbiter_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] dram_addr;
  logic                  dram_write_en;
  logic [DATA_WIDTH-1:0] dram_data_in;
  logic                  dram_refresh_data;
  logic                  dram_data_ready;
  logic [DATA_WIDTH-1:0] dram_read_data;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  dram_data_ready, dram_read_data,
    output ack0, ack1, rdata0, rdata1,
    output dram_addr, dram_write_en, dram_data_in, dram_refresh_data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output dram_data_ready, dram_read_data,
    input  ack0, ack1, rdata0, rdata1,
    input  dram_addr, dram_write_en, dram_data_in, dram_refresh_data
  );
endinterface

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-port round-robin arbiter in front of a single DRAM controller port
// Optional wait timeout enabled by defining DRAM_ARB_TIMEOUT_EN.
module dram_arbiter #(
  parameter int ADDR_WIDTH     = 25,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  dram_arbiter_if.slave   bus,
  output logic            busy,
  output logic            grant,
  output logic            timeout_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  last_grant;
  logic                  take;
  logic                  pick;
  logic                  tmo_hit;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt;
  logic       tmo_err_q;

  assign tmo_hit     = (state == WAIT) && !bus.dram_data_ready && (wait_cnt == TMO_LIMIT);
  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  // Without the counter the limit has no effect; this term is constant low.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          take = 1'b1;
          pick = ~last_grant;
        end else if (bus.req0) begin
          take = 1'b1;
          pick = 1'b0;
        end else if (bus.req1) begin
          take = 1'b1;
          pick = 1'b1;
        end
        if (take) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = WAIT;
      WAIT:    if (bus.dram_data_ready || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            addr_q     <= pick ? bus.addr1  : bus.addr0;
            we_q       <= pick ? bus.we1    : bus.we0;
            wdata_q    <= pick ? bus.wdata1 : bus.wdata0;
            grant      <= pick;
            last_grant <= pick;
          end
        end
`ifdef DRAM_ARB_TIMEOUT_EN
        ISSUE:  wait_cnt <= '0;
        SETTLE: wait_cnt <= wait_cnt + 8'd1;
`endif
        WAIT: begin
`ifdef DRAM_ARB_TIMEOUT_EN
          wait_cnt <= wait_cnt + 8'd1;
`endif
          if (bus.dram_data_ready) begin
            if (!we_q) begin
              if (grant) rdata1_q <= bus.dram_read_data;
              else       rdata0_q <= bus.dram_read_data;
            end
          end else if (tmo_hit) begin
            // A timed-out read returns a recognisable poison word.
            if (!we_q) begin
              if (grant) rdata1_q <= DATA_WIDTH'(16'hDEAD);
              else       rdata0_q <= DATA_WIDTH'(16'hDEAD);
            end
`ifdef DRAM_ARB_TIMEOUT_EN
            tmo_err_q <= 1'b1;
`endif
          end
        end
        DONE: we_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy                  = (state != IDLE);
  assign bus.dram_refresh_data = (state == ISSUE);
  assign bus.ack0              = (state == DONE) && !grant;
  assign bus.ack1              = (state == DONE) && grant;
  assign bus.dram_addr         = addr_q;
  assign bus.dram_write_en     = we_q;
  assign bus.dram_data_in      = wdata_q;
  assign bus.rdata0            = rdata0_q;
  assign bus.rdata1            = rdata1_q;

endmodule
